pipe_hazard_ctrl: RTL



---
 rtl/pipe_hazard_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush to per-register hold and bubble controls.
// Optional performance counters are built when PIPE_HAZARD_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl #(
    parameter int NSTAGE  = 5,
    parameter int IF_HOLD = 2,
    parameter int SW      = $clog2(NSTAGE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [NSTAGE-1:0] stall_req,
    input  logic              flush_req,
    input  logic [SW-1:0]     flush_upto,
    input  logic              if_busy,
    output logic [NSTAGE-1:0] hold_o,
    output logic [NSTAGE-1:0] bubble_o,
    output logic              if_discard_o,
    output logic              redirect_o,
    output logic [31:0]       stall_cycles_o,
    output logic [31:0]       flush_count_o
);

    localparam int CW = (IF_HOLD > 0) ? $clog2(IF_HOLD + 1) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [NSTAGE-1:0] hold_base;
    logic [NSTAGE-1:0] hold_pre;
    logic [NSTAGE-1:0] bub_pre;
    logic [SW-1:0]   upto_eff;
    logic            flush_start;

    assign upto_eff     = (flush_upto == '0) ? SW'(1) : flush_upto;
    assign flush_start  = rdy && flush_req && (state == IDLE);
    assign if_discard_o = (state == DRAIN);
    assign redirect_o   = rdy && (state == REDIRECT);

    always_comb begin
        hold_base = '0;
        for (int k = 0; k < NSTAGE; k++)
            hold_base[k] = |(stall_req >> k);

        hold_pre = hold_base;
        if (cnt != '0 || state == DRAIN)
            hold_pre[0] = 1'b1;
        if (state == REDIRECT)
            hold_pre[0] = 1'b0;

        bub_pre = '0;
        for (int k = 1; k < NSTAGE; k++)
            bub_pre[k] = hold_pre[k-1] & ~hold_pre[k];

        if (rdy) begin
            hold_o   = hold_pre;
            bubble_o = bub_pre;
            // Flush overrides stall on registers 1..flush_upto in every state.
            if (flush_req) begin
                for (int k = 1; k < NSTAGE; k++) begin
                    if (k <= int'(upto_eff)) begin
                        hold_o[k]   = 1'b0;
                        bubble_o[k] = 1'b1;
                    end
                end
            end
        end else begin
            hold_o   = '1;
            bubble_o = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (rdy) begin
            case (state)
                IDLE:     if (flush_req) state <= if_busy ? DRAIN : REDIRECT;
                DRAIN:    if (!if_busy)  state <= REDIRECT;
                REDIRECT: state <= IDLE;
                default:  state <= IDLE;
            endcase

            // The window only reloads from a plain stall, never while a flush is in progress.
            if (state == REDIRECT)
                cnt <= '0;
            else if (state == IDLE && !flush_req && stall_req[0])
                cnt <= CW'(IF_HOLD);
            else if (cnt != '0)
                cnt <= cnt - CW'(1);
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (rdy && hold_o[0])
                stall_cnt <= stall_cnt + 32'd1;
            if (flush_start)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign stall_cycles_o = stall_cnt;
    assign flush_count_o  = flush_cnt;
`else
    assign stall_cycles_o = '0;
    assign flush_count_o  = '0;
`endif

endmodule
